altsyncram: RTL and testbench
=============================

ALTSYNCRAM -- requirements
Module: altsyncram

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- width_a, 17, port A data width
- width_b, 17, port B data width (SHALL equal width_a)
- widthad_a, 11, port A address width
- widthad_b, 11, port B address width (SHALL equal widthad_a)
- numwords_a, 2048, depth (SHALL equal 2**widthad_a)
- numwords_b, 2048, depth as seen from B (SHALL equal numwords_a)
- operation_mode, "DUAL_PORT", only supported value
- read_during_write_mode_mixed_ports, "OLD_DATA", only supported value
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock0, input, 1, single clock for all state; rising edge
- reset, input, 1, synchronous, active-high; clears the output registers
- address_a, input, widthad_a, port A address
- data_a, input, width_a, port A write data
- wren_a, input, 1, port A write enable
- rden_a, input, 1, port A read enable
- q_a, output, width_a, port A registered read data
- address_b, input, widthad_b, port B address
- data_b, input, width_b, port B write data
- wren_b, input, 1, port B write enable
- rden_b, input, 1, port B read enable
- q_b, output, width_b, port B registered read data

Function
REQ-003 Storage SHALL be numwords_a words of width_a bits, shared by both ports.
REQ-004 On a clock0 rising edge with wren_a=1, mem[address_a] SHALL take data_a.
REQ-005 On a clock0 rising edge with wren_a=0 and wren_b=1, mem[address_b] SHALL take data_b.
REQ-006 If wren_a and wren_b are both 1, only the port A write SHALL occur, whatever the addresses; the port B write is dropped.
REQ-007 On a clock0 rising edge with rden_a=1 and reset=0, q_a SHALL load mem[address_a]; read latency is 1 cycle.
REQ-008 On a clock0 rising edge with rden_b=1 and reset=0, q_b SHALL load mem[address_b]; read latency is 1 cycle.
REQ-009 While rden_x=0, q_x SHALL hold its previous value.
REQ-010 A read of an address written on the same edge (same or other port) SHALL return the pre-write (old) data; the new data is visible on the next read.
REQ-011 Both ports SHALL be able to read the same or different addresses on the same edge.
REQ-012 Reads and writes SHALL be independent: a read and a write may occur on the same port on the same edge.

Reset
REQ-013 When reset=1 at a clock0 rising edge, q_a and q_b SHALL become 0, overriding rden_a and rden_b.
REQ-014 Reset SHALL NOT clear memory contents, and writes SHALL still take effect during reset.
REQ-015 Memory contents SHALL be undefined after power-up unless ALTSYNCRAM_DEBUG_EN is defined.

Configuration
REQ-016 With macro ALTSYNCRAM_DEBUG_EN defined, all words SHALL be initialised to 0 at time zero.
REQ-017 With ALTSYNCRAM_DEBUG_EN defined, each performed write SHALL print "dispatch[<addr octal>] <- <data octal>".
REQ-018 With ALTSYNCRAM_DEBUG_EN defined, each performed read SHALL print "dispatch[<addr octal>] -> <data octal>".
REQ-019 Without ALTSYNCRAM_DEBUG_EN there SHALL be no initialisation and no messages; the functional behaviour SHALL be otherwise identical.

Verification
REQ-020 Write/read: write A addr 0o17 data 0o123456; next cycle rden_a=1 at addr 0o17 -> q_a=0o123456 one cycle later; rden_b at 0o17 -> q_b=0o123456.
REQ-021 Write collision: wren_a=1 (addr 5, data 0x1AAAA) and wren_b=1 (addr 5, data 0x05555) on the same edge; read addr 5 -> 0x1AAAA. With addresses 5 and 6 instead: addr 6 keeps its prior value.
REQ-022 Old data: mem[9]=0x00011; write 0x00022 to addr 9 via B while rden_a reads addr 9 on the same edge -> q_a=0x00011; next read -> 0x00022.
REQ-023 Hold: load q_a=0x1FFFF, then keep rden_a=0 for 5 cycles while changing address_a -> q_a stays 0x1FFFF.
REQ-024 Reset: q_a and q_b nonzero; assert reset for 1 cycle with rden high -> q_a=q_b=0; deassert and read the previously written address -> the original data is returned (memory intact).
REQ-025 Boundaries: write/read addr 0 and addr 2047 with 0x1FFFF and 0x00001 -> correct data on both ports, no aliasing.

Source files
------------

// File: rtl/altsyncram.sv
// Simple dual-port RAM, single clock, port A wins write collisions, old-data mixed-port reads.
// Define ALTSYNCRAM_DEBUG_EN to zero-fill the array at time zero and log every performed access.
module altsyncram #(
   parameter int width_a                            = 17,
   parameter int width_b                            = 17,
   parameter int widthad_a                          = 11,
   parameter int widthad_b                          = 11,
   parameter int numwords_a                         = 2048,
   parameter int numwords_b                         = 2048,
   parameter     operation_mode                     = "DUAL_PORT",
   parameter     read_during_write_mode_mixed_ports = "OLD_DATA"
) (
   input  logic                 clock0,
   input  logic                 reset,
   input  logic [widthad_a-1:0] address_a,
   input  logic [width_a-1:0]   data_a,
   input  logic                 wren_a,
   input  logic                 rden_a,
   output logic [width_a-1:0]   q_a,
   input  logic [widthad_b-1:0] address_b,
   input  logic [width_b-1:0]   data_b,
   input  logic                 wren_b,
   input  logic                 rden_b,
   output logic [width_b-1:0]   q_b
);

   if (width_b != width_a || widthad_b != widthad_a || numwords_a != (1 << widthad_a) ||
       numwords_b != numwords_a || operation_mode != "DUAL_PORT" ||
       read_during_write_mode_mixed_ports != "OLD_DATA") begin : g_param_err
      $error("altsyncram: unsupported parameter combination");
   end

   logic [width_a-1:0]   mem_q [numwords_a];
   logic                 wr_en;
   logic [widthad_a-1:0] wr_addr;
   logic [width_a-1:0]   wr_data;
   logic [width_a-1:0]   q_a_q, q_a_d;
   logic [width_b-1:0]   q_b_q, q_b_d;

   // Single write port into the array: A has priority, B's write is dropped on collision.
   always_comb begin
      wr_en   = wren_a | wren_b;
      wr_addr = wren_a ? address_a : address_b;
      wr_data = wren_a ? data_a    : data_b;
   end

`ifdef ALTSYNCRAM_DEBUG_EN
   initial begin
      for (int i = 0; i < numwords_a; i++) mem_q[i] = '0;
   end
`endif

   // NOTE: the array has no reset term; clearing it would force flops instead of a RAM macro.
   always_ff @(posedge clock0) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
`ifdef ALTSYNCRAM_DEBUG_EN
         $display("dispatch[%o] <- %o", wr_addr, wr_data);
`endif
      end
   end

   // Reads sample the array before this edge's write lands, which yields old data.
   always_comb begin
      q_a_d = q_a_q;
      q_b_d = q_b_q;
      if (rden_a) q_a_d = mem_q[address_a];
      if (rden_b) q_b_d = mem_q[address_b];
      if (reset) begin
         q_a_d = '0;
         q_b_d = '0;
      end
   end

   // NOTE: non-blocking assignments keep every register update ordered against the same edge.
   always_ff @(posedge clock0) begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
`ifdef ALTSYNCRAM_DEBUG_EN
      if (!reset && rden_a) $display("dispatch[%o] -> %o", address_a, mem_q[address_a]);
      if (!reset && rden_b) $display("dispatch[%o] -> %o", address_b, mem_q[address_b]);
`endif
   end

   assign q_a = q_a_q;
   assign q_b = q_b_q;

endmodule

// File: tb/tb_altsyncram.sv
// Self-checking bench for altsyncram: directed scenarios followed by random traffic against a word-array model.
module tb_altsyncram;

   logic        clock0 = 1'b0;
   logic        reset;
   logic [10:0] address_a, address_b;
   logic [16:0] data_a, data_b;
   logic        wren_a, rden_a, wren_b, rden_b;
   logic [16:0] q_a, q_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: memory contents plus a flag per word saying whether its value is known.
   logic [16:0] ref_mem [2048];
   bit          ref_vld [2048];
   logic [16:0] exp_qa, exp_qb;
   bit          qa_known, qb_known;

   altsyncram dut (
      .clock0   (clock0),
      .reset    (reset),
      .address_a(address_a),
      .data_a   (data_a),
      .wren_a   (wren_a),
      .rden_a   (rden_a),
      .q_a      (q_a),
      .address_b(address_b),
      .data_b   (data_b),
      .wren_b   (wren_b),
      .rden_b   (rden_b),
      .q_b      (q_b)
   );

   always #5 clock0 = ~clock0;

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one edge's worth of inputs, advance the model, then compare both outputs.
   task automatic cycle(input bit rst,
                        input bit wa, input bit ra, input logic [10:0] aa, input logic [16:0] da,
                        input bit wb, input bit rb, input logic [10:0] ab, input logic [16:0] db);
      reset = rst;
      wren_a = wa; rden_a = ra; address_a = aa; data_a = da;
      wren_b = wb; rden_b = rb; address_b = ab; data_b = db;
      if (rst) begin
         exp_qa = '0; qa_known = 1'b1;
         exp_qb = '0; qb_known = 1'b1;
      end else begin
         if (ra) begin exp_qa = ref_mem[aa]; qa_known = ref_vld[aa]; end
         if (rb) begin exp_qb = ref_mem[ab]; qb_known = ref_vld[ab]; end
      end
      if (wa) begin
         ref_mem[aa] = da; ref_vld[aa] = 1'b1;
      end else if (wb) begin
         ref_mem[ab] = db; ref_vld[ab] = 1'b1;
      end
      @(posedge clock0);
      #1;
      if (qa_known) check("model_q_a", q_a, exp_qa);
      if (qb_known) check("model_q_b", q_b, exp_qb);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin ref_mem[i] = '0; ref_vld[i] = 1'b0; end
      qa_known = 1'b0; qb_known = 1'b0; exp_qa = '0; exp_qb = '0;
      reset = 1'b1; wren_a = 0; rden_a = 0; wren_b = 0; rden_b = 0;
      address_a = '0; address_b = '0; data_a = '0; data_b = '0;

      // Reset state with read enables high
      cycle(1, 0, 1, 11'd3, 17'h0, 0, 1, 11'd4, 17'h0);
      cycle(1, 0, 1, 11'd3, 17'h0, 0, 1, 11'd4, 17'h0);
      check("reset_q_a", q_a, 17'h0);
      check("reset_q_b", q_b, 17'h0);

      // Write on A, then read back on both ports
      cycle(0, 1, 0, 11'o17, 17'o123456, 0, 0, 11'd0, 17'h0);
      cycle(0, 0, 1, 11'o17, 17'h0, 0, 1, 11'o17, 17'h0);
      check("wr_rd_q_a", q_a, 17'o123456);
      check("wr_rd_q_b", q_b, 17'o123456);

      // Write collision, same address: A wins
      cycle(0, 1, 0, 11'd5, 17'h1AAAA, 1, 0, 11'd5, 17'h05555);
      cycle(0, 0, 1, 11'd5, 17'h0, 0, 1, 11'd5, 17'h0);
      check("coll_same_q_a", q_a, 17'h1AAAA);
      check("coll_same_q_b", q_b, 17'h1AAAA);

      // Write collision, different addresses: B's write dropped
      cycle(0, 1, 0, 11'd6, 17'h00666, 0, 0, 11'd0, 17'h0);
      cycle(0, 1, 0, 11'd5, 17'h1AAAA, 1, 0, 11'd6, 17'h05555);
      cycle(0, 0, 1, 11'd5, 17'h0, 0, 1, 11'd6, 17'h0);
      check("coll_diff_a5", q_a, 17'h1AAAA);
      check("coll_diff_b6", q_b, 17'h00666);

      // Mixed-port read during write returns old data
      cycle(0, 1, 0, 11'd9, 17'h00011, 0, 0, 11'd0, 17'h0);
      cycle(0, 0, 1, 11'd9, 17'h0, 1, 0, 11'd9, 17'h00022);
      check("old_data", q_a, 17'h00011);
      cycle(0, 0, 1, 11'd9, 17'h0, 0, 0, 11'd0, 17'h0);
      check("new_data", q_a, 17'h00022);

      // Same-port read and write on one edge
      cycle(0, 1, 1, 11'd9, 17'h00033, 0, 0, 11'd0, 17'h0);
      check("same_port_old", q_a, 17'h00022);

      // Hold while rden_a is low
      cycle(0, 1, 0, 11'd100, 17'h1FFFF, 0, 0, 11'd0, 17'h0);
      cycle(0, 0, 1, 11'd100, 17'h0, 0, 1, 11'o17, 17'h0);
      check("hold_load", q_a, 17'h1FFFF);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 11'(i * 7 + 1), 17'h0, 0, 0, 11'd0, 17'h0);
         check("hold", q_a, 17'h1FFFF);
      end

      // Reset clears outputs, leaves memory intact, still accepts writes
      cycle(1, 1, 1, 11'd200, 17'h0BEEF, 0, 1, 11'd100, 17'h0);
      check("rst_q_a", q_a, 17'h0);
      check("rst_q_b", q_b, 17'h0);
      cycle(0, 0, 1, 11'd100, 17'h0, 0, 1, 11'd200, 17'h0);
      check("post_rst_mem", q_a, 17'h1FFFF);
      check("rst_write", q_b, 17'h0BEEF);

      // Address boundaries
      cycle(0, 1, 0, 11'd0, 17'h1FFFF, 0, 0, 11'd0, 17'h0);
      cycle(0, 0, 0, 11'd0, 17'h0, 1, 0, 11'd2047, 17'h00001);
      cycle(0, 0, 1, 11'd0, 17'h0, 0, 1, 11'd2047, 17'h0);
      check("bnd_a0", q_a, 17'h1FFFF);
      check("bnd_b2047", q_b, 17'h00001);
      cycle(0, 0, 1, 11'd2047, 17'h0, 0, 1, 11'd0, 17'h0);
      check("bnd_a2047", q_a, 17'h00001);
      check("bnd_b0", q_b, 17'h1FFFF);

      // Random traffic on a small address window plus the top word
      for (int n = 0; n < 600; n++) begin
         logic [10:0] ra_addr, rb_addr;
         ra_addr = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
         rb_addr = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
         cycle(($urandom_range(0, 31) == 0),
               1'($urandom), 1'($urandom), ra_addr, 17'($urandom),
               1'($urandom), 1'($urandom), rb_addr, 17'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
